// File: rtl/dog_extrema.sv
// 3x3x3 DoG extremum scanner: walks interior pixels of the middle level and streams strict local maxima/minima.
// Optional contrast gate: define DOG_EXTREMA_CONTRAST_EN to also require |centre| > CONTRAST_THRESH.
module dog_extrema #(
  parameter int DIMENSION       = 64,
  parameter int BIT_DEPTH       = 9,
  parameter int CONTRAST_THRESH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] addr,
  input  logic signed [BIT_DEPTH-1:0]          data_below,
  input  logic signed [BIT_DEPTH-1:0]          data_mid,
  input  logic signed [BIT_DEPTH-1:0]          data_above,
  output logic                                 kp_valid,
  input  logic                                 kp_ready,
  output logic [$clog2(DIMENSION)-1:0]         kp_x,
  output logic [$clog2(DIMENSION)-1:0]         kp_y,
  output logic                                 kp_is_max
);

  localparam int AW = $clog2(DIMENSION*DIMENSION);
  localparam int CW = $clog2(DIMENSION);
  localparam logic [CW-1:0] EDGE = CW'(DIMENSION - 2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    DECIDE,
    EMIT
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] x, y;
  logic [CW-1:0] nx, ny;
  logic          last;
  logic [3:0]    cnt;
  logic [3:0]    cap_idx;
  logic          capture;

  logic signed [BIT_DEPTH-1:0] below_r [9];
  logic signed [BIT_DEPTH-1:0] mid_r   [9];
  logic signed [BIT_DEPTH-1:0] above_r [9];

  logic signed [BIT_DEPTH-1:0] centre;
  logic gt_all, lt_all, contrast_ok, is_kp;

  // Tap k of the 3x3 window centred on (px,py), raster order over (dy,dx).
  function automatic logic [AW-1:0] tap_addr(input logic [CW-1:0] px,
                                             input logic [CW-1:0] py,
                                             input logic [3:0]    k);
    int unsigned kk, row, col;
    kk  = k;
    row = int'(py) - 1 + kk / 3;
    col = int'(px) - 1 + kk % 3;
    return AW'(row * DIMENSION + col);
  endfunction

  always_comb begin
    last = (x == EDGE) && (y == EDGE);
    if (x == EDGE) begin
      nx = CW'(1);
      ny = y + CW'(1);
    end else begin
      nx = x + CW'(1);
      ny = y;
    end
  end

  always_comb begin
    centre = mid_r[4];
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!(centre > below_r[i])) gt_all = 1'b0;
      if (!(centre < below_r[i])) lt_all = 1'b0;
      if (!(centre > above_r[i])) gt_all = 1'b0;
      if (!(centre < above_r[i])) lt_all = 1'b0;
      if (i != 4) begin
        if (!(centre > mid_r[i])) gt_all = 1'b0;
        if (!(centre < mid_r[i])) lt_all = 1'b0;
      end
    end
  end

`ifdef DOG_EXTREMA_CONTRAST_EN
  logic signed [BIT_DEPTH:0] cext, mag;
  always_comb begin
    cext        = centre;
    mag         = (cext < 0) ? -cext : cext;
    contrast_ok = mag > $signed((BIT_DEPTH+1)'(CONTRAST_THRESH));
  end
`else
  always_comb contrast_ok = 1'b1;
`endif

  always_comb is_kp = (gt_all || lt_all) && contrast_ok;

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    kp_valid   = (state == EMIT);
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH:  if (cnt == 4'd8) state_next = DRAIN;
      DRAIN:  if (cnt == 4'd10) state_next = DECIDE;
      DECIDE: begin
        if (is_kp)     state_next = EMIT;
        else if (last) state_next = IDLE;
        else           state_next = FETCH;
      end
      EMIT:   if (kp_ready) state_next = last ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // The next pixel's first tap address is loaded on the advancing edge so FETCH k shows tap k.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      addr      <= '0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      kp_x      <= '0;
      kp_y      <= '0;
      kp_is_max <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x    <= CW'(1);
            y    <= CW'(1);
            cnt  <= '0;
            addr <= tap_addr(CW'(1), CW'(1), 4'd0);
          end
        end
        FETCH: begin
          cnt <= cnt + 4'd1;
          if (cnt < 4'd8) addr <= tap_addr(x, y, cnt + 4'd1);
        end
        DRAIN: cnt <= cnt + 4'd1;
        DECIDE, EMIT: begin
          if (state == DECIDE && is_kp) begin
            kp_x      <= x;
            kp_y      <= y;
            kp_is_max <= gt_all;
          end else if (state == DECIDE || kp_ready) begin
            if (last) begin
              done <= 1'b1;
            end else begin
              x    <= nx;
              y    <= ny;
              cnt  <= '0;
              addr <= tap_addr(nx, ny, 4'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Two-cycle BRAM latency: tap k arrives in scan cycle k+2.
  always_comb begin
    cap_idx = cnt - 4'd2;
    capture = ((state == FETCH) || (state == DRAIN)) && (cnt >= 4'd2);
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      below_r[cap_idx] <= data_below;
      mid_r[cap_idx]   <= data_mid;
      above_r[cap_idx] <= data_above;
    end
  end

endmodule

// File: tb/tb_dog_extrema.sv
// Scoreboard bench for dog_extrema on an 8x8 image with behavioural 2-cycle-latency BRAMs.
module tb_dog_extrema;

  localparam int D  = 8;
  localparam int BD = 9;

  logic clk = 1'b0;
  logic rst_in, start, busy, done, kp_valid, kp_ready, kp_is_max;
  logic [5:0] addr;
  logic [2:0] kp_x, kp_y;
  logic signed [BD-1:0] data_below, data_mid, data_above;

  logic signed [BD-1:0] mem_b [D*D];
  logic signed [BD-1:0] mem_m [D*D];
  logic signed [BD-1:0] mem_a [D*D];
  logic signed [BD-1:0] s1_b, s1_m, s1_a;

  typedef struct { int x; int y; int mx; } kp_t;
  kp_t sb [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dog_extrema #(.DIMENSION(D), .BIT_DEPTH(BD), .CONTRAST_THRESH(3)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
    .addr(addr), .data_below(data_below), .data_mid(data_mid), .data_above(data_above),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y), .kp_is_max(kp_is_max)
  );

  always @(posedge clk) begin
    s1_b <= mem_b[addr];
    s1_m <= mem_m[addr];
    s1_a <= mem_a[addr];
    data_below <= s1_b;
    data_mid   <= s1_m;
    data_above <= s1_a;
  end

  // Monitor: every accepted keypoint is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_in && kp_valid && kp_ready) begin
      kp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL kp_unexpected actual=(%0d,%0d,%0d) required=none", kp_x, kp_y, kp_is_max);
      end else begin
        e = sb.pop_front();
        if (int'(kp_x) != e.x || int'(kp_y) != e.y || int'(kp_is_max) != e.mx) begin
          errors++;
          $display("FAIL kp_fields actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                   kp_x, kp_y, kp_is_max, e.x, e.y, e.mx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < D*D; i++) begin
      mem_b[i] = '0;
      mem_m[i] = '0;
      mem_a[i] = '0;
    end
  endtask

  task automatic expect_kp(input int x, input int y, input int mx);
    kp_t e;
    e.x = x; e.y = y; e.mx = mx;
    sb.push_back(e);
  endtask

  // Pulses start and counts cycles from the first FETCH cycle to the done pulse.
  task automatic run_scan(input string name, input int exp_cycles);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy_rise"}, int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check({name, "_cycles"}, cyc, exp_cycles);
      check({name, "_busy_at_done"}, int'(busy), 0);
    end
    tick();
    check({name, "_done_pulse"}, int'(done), 0);
    check({name, "_sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int n, hold_bad;
    logic [2:0] sx, sy;
    logic sm;
    logic [5:0] sa;

    rst_in = 1'b1; start = 1'b0; kp_ready = 1'b1;
    clear_mem();
    tick(); tick();
    start = 1'b1;
    tick();
    check("rst_addr", int'(addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_kp_valid", int'(kp_valid), 0);
    check("rst_kp_xy", int'({kp_x, kp_y}), 0);
    check("rst_kp_is_max", int'(kp_is_max), 0);
    start = 1'b0; rst_in = 1'b0;
    tick();
    check("idle_after_rst", int'(busy), 0);

    // All zero: 36 pixels x 12 cycles.
    run_scan("zero", 432);

    clear_mem();
    mem_m[4*D + 3] = 9'sd20;
    expect_kp(3, 4, 1);
    run_scan("max", 433);

    clear_mem();
    mem_m[2*D + 5] = -9'sd20;
    expect_kp(5, 2, 0);
    run_scan("min", 433);

    clear_mem();
    mem_m[4*D + 3] = 9'sd20;
    mem_a[4*D + 4] = 9'sd20;
    run_scan("tie", 432);

    clear_mem();
    mem_m[4*D + 3] = 9'sd3;
`ifdef DOG_EXTREMA_CONTRAST_EN
    run_scan("contrast", 432);
`else
    expect_kp(3, 4, 1);
    run_scan("contrast", 433);
`endif

    // Interior corners are valid centres; border spike never is.
    clear_mem();
    mem_m[1*D + 1] = 9'sd20;
    mem_m[6*D + 6] = -9'sd20;
    mem_m[7*D + 0] = 9'sd50;
    expect_kp(1, 1, 1);
    expect_kp(6, 6, 0);
    run_scan("corners", 434);

    // Backpressure: 50 cycles of kp_ready low while EMIT holds.
    clear_mem();
    mem_m[4*D + 3] = 9'sd20;
    kp_ready = 1'b0;
    expect_kp(3, 4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!kp_valid && n < 1000) begin tick(); n++; end
    check("bp_valid_seen", int'(kp_valid), 1);
    sx = kp_x; sy = kp_y; sm = kp_is_max; sa = addr;
    check("bp_hold_addr", int'(sa), 5*D + 4);
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!kp_valid || kp_x != sx || kp_y != sy || kp_is_max != sm || addr != sa || !busy)
        hold_bad++;
    end
    check("bp_hold_stable", hold_bad, 0);
    kp_ready = 1'b1;
    tick();
    check("bp_accept_first", int'(kp_valid), 0);
    n = 0;
    while (!done && n < 1000) begin tick(); n++; end
    check("bp_done", int'(done), 1);
    tick();
    check("bp_sb_empty", sb.size(), 0);
    sb.delete();

    // Reset during EMIT discards the keypoint.
    kp_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!kp_valid && n < 1000) begin tick(); n++; end
    check("rst_emit_valid_seen", int'(kp_valid), 1);
    tick(); tick();
    rst_in = 1'b1;
    tick();
    check("rst_emit_kp_valid", int'(kp_valid), 0);
    check("rst_emit_busy", int'(busy), 0);
    check("rst_emit_addr", int'(addr), 0);
    rst_in = 1'b0;
    kp_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_emit_stays_idle", int'({busy, kp_valid}), 0);
    check("rst_emit_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
